// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, bubble instruction and
// instruction-fetch exception codes.
package fetch_pkg;

  typedef enum logic [0:0] {
    ST_FETCH      = 1'b0,
    ST_FAULT_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

  typedef struct packed {
    logic        en;
    logic [3:0]  code;
    logic [63:0] val;
  } fetch_exc_t;

  function automatic logic pc_misaligned(input logic [63:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect port and the
// valid/ready output towards decode.
interface ifetch_ctrl_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;

  logic        redirect_valid;
  logic [63:0] redirect_pc;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;
  logic [63:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val,
    input  out_ready,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val,
    output out_ready,
    input  fetch_count
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: PC register, single-entry output stage to
// decode, fault hold-off until redirect, and a transfer counter.
module ifetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_ctrl_if.master bus
);
  import fetch_pkg::*;

  fetch_state_e state_q, state_d;

  logic [63:0] pc_q;
  logic        out_valid_q;
  logic [63:0] out_pc_q;
  logic [31:0] out_instr_q;
  fetch_exc_t  out_exc_q;
  logic [63:0] fetch_count_q;

  logic       slot_free;
  logic       xfer;
  logic       capture;
  fetch_exc_t cap_exc;
  logic [31:0] cap_instr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid)          state_d = ST_FETCH;
    else if (capture && cap_exc.en)  state_d = ST_FAULT_WAIT;
  end

  // Output/control decode; misalignment outranks a memory fault
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    xfer      = out_valid_q && bus.out_ready;
    capture   = (state_q == ST_FETCH) && slot_free && !bus.redirect_valid;
    cap_exc   = '{en: bus.imem_exc_en, code: bus.imem_exc_code, val: bus.imem_exc_val};
    cap_instr = bus.imem_instr;
    if (pc_misaligned(pc_q)) begin
      cap_exc   = '{en: 1'b1, code: EXC_INSTR_MISALIGNED, val: pc_q};
      cap_instr = NOP_INSTR;
    end else if (bus.imem_exc_en) begin
      cap_instr = NOP_INSTR;
    end
  end

  // A transfer coincident with redirect still counts before the flush
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_instr_q   <= NOP_INSTR;
      out_exc_q     <= '0;
      fetch_count_q <= '0;
    end else begin
      if (xfer) fetch_count_q <= fetch_count_q + 64'd1;
      if (bus.redirect_valid) begin
        pc_q         <= bus.redirect_pc;
        out_valid_q  <= 1'b0;
        out_exc_q.en <= 1'b0;
        out_instr_q  <= NOP_INSTR;
      end else if (capture) begin
        out_valid_q <= 1'b1;
        out_pc_q    <= pc_q;
        out_instr_q <= cap_instr;
        out_exc_q   <= cap_exc;
        if (!cap_exc.en) pc_q <= pc_q + 64'd4;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.out_exc_en   = out_exc_q.en;
  assign bus.out_exc_code = out_exc_q.code;
  assign bus.out_exc_val  = out_exc_q.val;
  assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized
// ready/redirect/reset traffic against a behavioural fetch model.
module tb_ifetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  ifetch_ctrl_if bus();

  ifetch_ctrl #(.RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: fault window 0x2000-0x2FFF, content derived from address
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0003;
  endfunction
  function automatic logic mem_fault(input logic [63:0] a);
    return a[63:12] == 52'h2;
  endfunction

  always_comb begin
    bus.imem_instr    = mem_word(bus.imem_addr);
    bus.imem_exc_en   = mem_fault(bus.imem_addr);
    bus.imem_exc_code = mem_fault(bus.imem_addr) ? 4'd1 : 4'd0;
    bus.imem_exc_val  = mem_fault(bus.imem_addr) ? bus.imem_addr : 64'h0;
  end

  // Behavioural model: next address, halted-after-fault flag, presented entry, count
  logic [63:0] m_pc, m_opc, m_val, m_cnt;
  logic        m_halt, m_valid, m_exc;
  logic [31:0] m_instr;
  logic [3:0]  m_code;

  task automatic model_update();
    bit take;
    if (rst) begin
      m_pc = 64'h0; m_halt = 0; m_valid = 0; m_opc = 0; m_instr = NOP;
      m_exc = 0; m_code = 0; m_val = 0; m_cnt = 0;
      return;
    end
    take = m_valid && bus.out_ready;
    if (take) m_cnt = m_cnt + 1;
    if (bus.redirect_valid) begin
      m_pc = bus.redirect_pc; m_valid = 0; m_exc = 0; m_instr = NOP; m_halt = 0;
    end else if (!m_halt && (!m_valid || bus.out_ready)) begin
      m_valid = 1; m_opc = m_pc;
      if (m_pc % 4 != 0) begin
        m_exc = 1; m_code = 4'd0; m_val = m_pc; m_instr = NOP; m_halt = 1;
      end else if (mem_fault(m_pc)) begin
        m_exc = 1; m_code = 4'd1; m_val = m_pc; m_instr = NOP; m_halt = 1;
      end else begin
        m_exc = 0; m_code = 4'd0; m_val = 0; m_instr = mem_word(m_pc); m_pc = m_pc + 4;
      end
    end else if (take) begin
      m_valid = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; bus.out_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    step(); step();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_pc !== 64'h0) $display("FAIL rst_out_pc got=%h exp=0", bus.out_pc); else n_pass++;
    n_total++; if (bus.out_instr !== NOP) $display("FAIL rst_instr got=%h exp=%h", bus.out_instr, NOP); else n_pass++;
    n_total++; if ({bus.out_exc_en, bus.out_exc_code, bus.out_exc_val} !== 69'h0)
      $display("FAIL rst_exc got=%b/%h/%h exp=0", bus.out_exc_en, bus.out_exc_code, bus.out_exc_val); else n_pass++;
    n_total++; if (bus.fetch_count !== 64'h0) $display("FAIL rst_count got=%0d exp=0", bus.fetch_count); else n_pass++;
    n_total++; if (bus.imem_addr !== 64'h0) $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc;
    rst = 0; bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = 64'(i * 4);
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc)
        $display("FAIL seq_pc%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_pc, exp_pc); else n_pass++;
      n_total++; if (bus.out_instr !== mem_word(exp_pc))
        $display("FAIL seq_instr%0d got=%h exp=%h", i, bus.out_instr, mem_word(exp_pc)); else n_pass++;
    end
    step();
    n_total++; if (bus.fetch_count !== 64'd3) $display("FAIL seq_count got=%0d exp=3", bus.fetch_count); else n_pass++;
  endtask

  task automatic test_stall();
    rst = 1; step(); rst = 0; bus.out_ready = 1;
    step(); step(); step();
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (bus.out_pc !== 64'h8 || bus.out_instr !== mem_word(64'h8) || bus.out_valid !== 1'b1)
        $display("FAIL stall_out%0d got=%h/%h exp=8/%h", i, bus.out_pc, bus.out_instr, mem_word(64'h8)); else n_pass++;
      n_total++; if (bus.imem_addr !== 64'hC) $display("FAIL stall_addr%0d got=%h exp=c", i, bus.imem_addr); else n_pass++;
    end
    bus.out_ready = 1; step();
    n_total++; if (bus.out_pc !== 64'hC) $display("FAIL stall_release got=%h exp=c", bus.out_pc); else n_pass++;
  endtask

  task automatic test_redirect();
    logic [63:0] c0;
    bus.out_ready = 0; bus.redirect_valid = 1; bus.redirect_pc = 64'h100;
    step();
    bus.redirect_valid = 0;
    n_total++; if (bus.out_valid !== 1'b0 || bus.out_instr !== NOP || bus.out_exc_en !== 1'b0)
      $display("FAIL redir_flush got=%b/%h/%b exp=0/%h/0", bus.out_valid, bus.out_instr, bus.out_exc_en, NOP); else n_pass++;
    n_total++; if (bus.imem_addr !== 64'h100) $display("FAIL redir_addr got=%h exp=100", bus.imem_addr); else n_pass++;
    step();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h100)
      $display("FAIL redir_first got=%b/%h exp=1/100", bus.out_valid, bus.out_pc); else n_pass++;
    c0 = bus.fetch_count;
    bus.out_ready = 1; bus.redirect_valid = 1; bus.redirect_pc = 64'h40;
    step();
    bus.redirect_valid = 0;
    n_total++; if (bus.fetch_count !== c0 + 1 || bus.out_valid !== 1'b0)
      $display("FAIL redir_xfer got=%0d/%b exp=%0d/0", bus.fetch_count, bus.out_valid, c0 + 1); else n_pass++;
  endtask

  task automatic test_fault();
    logic [63:0] c0;
    bus.out_ready = 0; bus.redirect_valid = 1; bus.redirect_pc = 64'h2000;
    step();
    bus.redirect_valid = 0; bus.out_ready = 1;
    step();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_exc_en !== 1'b1 || bus.out_exc_code !== 4'd1 ||
                   bus.out_exc_val !== 64'h2000 || bus.out_instr !== NOP || bus.out_pc !== 64'h2000)
      $display("FAIL fault_entry got=%b/%b/%h/%h/%h exp=1/1/1/2000/%h", bus.out_valid, bus.out_exc_en,
               bus.out_exc_code, bus.out_exc_val, bus.out_instr, NOP); else n_pass++;
    c0 = bus.fetch_count;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 64'h2000 || bus.fetch_count !== c0 + 1)
        $display("FAIL fault_hold%0d got=%b/%h/%0d exp=0/2000/%0d", i, bus.out_valid, bus.imem_addr,
                 bus.fetch_count, c0 + 1); else n_pass++;
    end
  endtask

  task automatic test_misaligned_reset();
    bus.redirect_valid = 1; bus.redirect_pc = 64'h102;
    step();
    bus.redirect_valid = 0; bus.out_ready = 0;
    step();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_exc_en !== 1'b1 || bus.out_exc_code !== 4'd0 ||
                   bus.out_exc_val !== 64'h102 || bus.out_instr !== NOP)
      $display("FAIL misal_entry got=%b/%b/%h/%h/%h exp=1/1/0/102/%h", bus.out_valid, bus.out_exc_en,
               bus.out_exc_code, bus.out_exc_val, bus.out_instr, NOP); else n_pass++;
    step();
    n_total++; if (bus.imem_addr !== 64'h102 || bus.out_exc_val !== 64'h102)
      $display("FAIL misal_stall got=%h/%h exp=102/102", bus.imem_addr, bus.out_exc_val); else n_pass++;
    rst = 1; bus.out_ready = 1; bus.redirect_valid = 1; bus.redirect_pc = 64'h500;
    step();
    n_total++; if (bus.out_valid !== 1'b0 || bus.fetch_count !== 64'h0 || bus.imem_addr !== 64'h0 ||
                   bus.out_pc !== 64'h0 || bus.out_instr !== NOP || bus.out_exc_en !== 1'b0 ||
                   bus.out_exc_code !== 4'd0 || bus.out_exc_val !== 64'h0)
      $display("FAIL midstall_rst got=%b/%0d/%h/%h/%h/%b exp=0/0/0/0/%h/0", bus.out_valid, bus.fetch_count,
               bus.imem_addr, bus.out_pc, bus.out_instr, bus.out_exc_en, NOP); else n_pass++;
    bus.redirect_valid = 0; rst = 0; bus.out_ready = 0;
    step();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0)
      $display("FAIL post_rst_capture got=%b/%h exp=1/0", bus.out_valid, bus.out_pc); else n_pass++;
  endtask

  task automatic test_random();
    int unsigned errs = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: bus.redirect_pc = 64'($urandom_range(0, 255)) << 2;
        1: bus.redirect_pc = {$urandom, $urandom};
        2: bus.redirect_pc = 64'h2000 + (64'($urandom_range(0, 15)) << 2);
        default: bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
      endcase
      step();
      n_total++;
      if (bus.imem_addr !== m_pc || bus.out_valid !== m_valid || bus.out_pc !== m_opc ||
          bus.out_instr !== m_instr || bus.out_exc_en !== m_exc || bus.out_exc_code !== m_code ||
          bus.out_exc_val !== m_val || bus.fetch_count !== m_cnt) begin
        errs++;
        if (errs <= 10)
          $display("FAIL rand_cycle%0d got=a%h v%b p%h i%h e%b c%h x%h n%0d exp=a%h v%b p%h i%h e%b c%h x%h n%0d", i,
                   bus.imem_addr, bus.out_valid, bus.out_pc, bus.out_instr, bus.out_exc_en, bus.out_exc_code,
                   bus.out_exc_val, bus.fetch_count, m_pc, m_valid, m_opc, m_instr, m_exc, m_code, m_val, m_cnt);
      end else n_pass++;
    end
    rst = 0; bus.redirect_valid = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault();
    test_misaligned_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 64'h0, PC loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h00000013, instruction value presented when no valid fetch data exists.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_addr  output  64  fetch address to instruction memory; equals the internal PC register.
REQ-006 imem_instr  input  32  combinational read data from instruction memory.
REQ-007 imem_exc_en / imem_exc_code / imem_exc_val  input  1/4/64  memory access-fault indication for imem_addr.
REQ-008 redirect_valid / redirect_pc  input  1/64  flush and restart fetch at redirect_pc (branch, trap, mret).
REQ-009 out_valid / out_ready  output/input  1/1  valid-ready handshake to decode; transfer when both high at a clock edge.
REQ-010 out_pc / out_instr  output  64/32  PC and instruction of the presented entry.
REQ-011 out_exc_en / out_exc_code / out_exc_val  output  1/4/64  exception attached to the presented entry.
REQ-012 fetch_count  output  64  count of entries transferred to decode.

Function
REQ-013 States: FETCH (issuing fetches), FAULT_WAIT (exception entry issued; no further fetch until redirect).
REQ-014 Output stage is one register; "slot free" = !out_valid || out_ready.
REQ-015 In FETCH with slot free and no redirect: capture imem_instr and imem exception signals with out_pc=PC, set out_valid=1, PC<=PC+4 (mod 2^64); latency one cycle from address to out_valid.
REQ-016 Slot not free: PC, output registers and state hold unchanged (stall); out_* stable while out_valid && !out_ready.
REQ-017 PC[1:0]!=0 at capture: entry has out_exc_en=1, out_exc_code=4'd0 (misaligned), out_exc_val=PC, out_instr=NOP_INSTR; takes priority over imem_exc_en.
REQ-018 imem_exc_en=1 at capture: entry has out_exc_en=1, code/val copied from imem, out_instr=NOP_INSTR.
REQ-019 Any exception entry captured: state->FAULT_WAIT, PC not incremented.
REQ-020 FAULT_WAIT: no capture; out_valid clears after the exception entry transfers; remain until redirect.
REQ-021 redirect_valid=1 (any state): highest priority; PC<=redirect_pc, out_valid<=0, out_exc_en<=0, out_instr<=NOP_INSTR, state->FETCH; no capture that cycle.
REQ-022 Redirect coincident with a transfer (out_valid && out_ready): the transfer counts as complete (fetch_count increments), then flush applies.
REQ-023 fetch_count increments by 1 on every transfer, including exception entries; wraps 2^64-1 -> 0.
REQ-024 Redirect target misaligned: first capture after redirect yields REQ-017 entry.

Reset
REQ-025 On rst: PC=RESET_PC, state=FETCH, out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_exc_en=0, out_exc_code=0, out_exc_val=0, fetch_count=0.
REQ-026 rst overrides redirect and handshake in the same cycle; a pending output entry is discarded and not counted.
REQ-027 First capture occurs on the first edge after rst deasserts.

Structure
REQ-028 Shared package fetch_pkg holds: state encoding, NOP_INSTR value, exception codes EXC_INSTR_MISALIGNED=4'd0, EXC_INSTR_ACCESS_FAULT=4'd1.
REQ-029 No sub-module; the instruction memory is instantiated beside this block by the core top, driven from imem_addr.

Verification
REQ-030 Reset then out_ready=1 held: out_pc sequence 0x0,0x4,0x8 on consecutive cycles with out_valid=1; fetch_count=3 after three transfers.
REQ-031 out_ready=0 for 3 cycles at out_pc=0x8: out_pc/out_instr stable, imem_addr stays 0xC; release -> 0xC next.
REQ-032 redirect_pc=0x100 while out_valid=1, out_ready=0: next cycle out_valid=0; following cycle out_pc=0x100.
REQ-033 Fetch at PC=0x2000 with imem_exc_en=1, code=1: entry out_exc_en=1, code=1, val=0x2000, instr=0x00000013; afterwards out_valid=0 and imem_addr held until redirect.
REQ-034 redirect_pc=0x102: entry code=0, val=0x102, state FAULT_WAIT; rst asserted mid-stall -> all REQ-025 values next cycle.
